// File: rtl/sign_extension_pkg.sv
// sign_extension_pkg: shared widths and extension-mode encoding for the immediate extender
package sign_extension_pkg;
    localparam int SE_IN_W_DEF  = 3;
    localparam int SE_OUT_W_DEF = 8;
    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_e;
endpackage

// File: rtl/sign_extension_core.sv
// sign_extend_core: combinational sign/zero extension of an immediate field
// Ports: input_bits [IN_W-1:0] immediate, zero_ext mode select (0 sign, 1 zero),
//        ext_bits [OUT_W-1:0] extended result.
module sign_extend_core
    import sign_extension_pkg::*;
#(
    parameter int IN_W  = SE_IN_W_DEF,
    parameter int OUT_W = SE_OUT_W_DEF
) (
    input  logic [IN_W-1:0]  input_bits,
    input  logic             zero_ext,
    output logic [OUT_W-1:0] ext_bits
);
    if (IN_W < 1) begin : g_err_in_w
        $error("sign_extend_core: IN_W must be at least 1");
    end
    if (IN_W > OUT_W) begin : g_err_widths
        $error("sign_extend_core: IN_W must not exceed OUT_W");
    end
    if (IN_W == OUT_W) begin : g_pass
        // Nothing to replicate; the mode select has no effect at equal widths.
        logic unused_zero_ext;
        assign unused_zero_ext = zero_ext;
        assign ext_bits = input_bits;
    end else begin : g_ext
        logic fill;
        assign fill = (ext_mode_e'(zero_ext) == EXT_ZERO) ? 1'b0 : input_bits[IN_W-1];
        assign ext_bits = {{(OUT_W-IN_W){fill}}, input_bits};
    end
endmodule

// File: rtl/sign_extension.sv
// sign_extension: registered immediate extender with valid flag and sign indicator
// Ports: clk, rst_n (async active-low), in_valid/input_bits/zero_ext from decode,
//        out_valid/extended_bits/is_negative toward the ALU operand stage (1-cycle latency).
module sign_extension
    import sign_extension_pkg::*;
#(
    parameter int IN_W  = SE_IN_W_DEF,
    parameter int OUT_W = SE_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  input_bits,
    input  logic             zero_ext,
    output logic             out_valid,
    output logic [OUT_W-1:0] extended_bits,
    output logic             is_negative
);
    logic [OUT_W-1:0] core_bits;
    logic [OUT_W-1:0] ext_q, ext_d;
    logic             valid_q, valid_d;
    logic             neg_q, neg_d;

    sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .input_bits (input_bits),
        .zero_ext   (zero_ext),
        .ext_bits   (core_bits)
    );

    // Data holds while idle; only the valid flag tracks in_valid every cycle.
    always_comb begin
        ext_d   = in_valid ? core_bits : ext_q;
        neg_d   = in_valid ? core_bits[OUT_W-1] : neg_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q   <= '0;
            valid_q <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            valid_q <= valid_d;
            neg_q   <= neg_d;
        end
    end

    assign extended_bits = ext_q;
    assign out_valid     = valid_q;
    assign is_negative   = neg_q;
endmodule

// File: tb/tb_sign_extension.sv
// tb_sign_extension: randomized and directed self-checking bench for sign_extension
module tb_sign_extension;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] input_bits = '0;
    logic       zero_ext = 1'b0;
    logic       out_valid;
    logic [7:0] extended_bits;
    logic       is_negative;

    int checks = 0;
    int errors = 0;

    sign_extension dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .input_bits    (input_bits),
        .zero_ext      (zero_ext),
        .out_valid     (out_valid),
        .extended_bits (extended_bits),
        .is_negative   (is_negative)
    );

    always #5 clk = ~clk;

    // Reference: interpret the field as a two's-complement or unsigned number, wrap to 8 bits.
    function automatic logic [7:0] ref_ext(input logic [2:0] b, input logic z);
        int v;
        v = int'(b);
        if (!z && v >= 4) v = v - 8;
        return 8'(v);
    endfunction

    task automatic step(input logic v, input logic [2:0] b, input logic z);
        in_valid = v;
        input_bits = b;
        zero_ext = z;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom), 3'($urandom), 1'($urandom));
            checks++;
            if (extended_bits !== 8'h00 || out_valid !== 1'b0 || is_negative !== 1'b0) begin
                errors++;
                $display("FAIL reset: ext=%h valid=%b neg=%b, want 00/0/0", extended_bits, out_valid, is_negative);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0] b [6] = '{3'b101, 3'b001, 3'b011, 3'b101, 3'b111, 3'b110};
        logic       z [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] e [6] = '{8'hFD, 8'h01, 8'h03, 8'h05, 8'h07, 8'hFE};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, b[i], z[i]);
            checks++;
            if (extended_bits !== e[i] || out_valid !== 1'b1 || is_negative !== e[i][7]) begin
                errors++;
                $display("FAIL directed[%0d]: ext=%h valid=%b neg=%b, want %h/1/%b",
                         i, extended_bits, out_valid, is_negative, e[i], e[i][7]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_e;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 3'(i), 1'(m));
                exp_e = (m == 1) ? 8'(i) : ((i < 4) ? 8'(i) : 8'(i + 248));
                checks++;
                if (extended_bits !== exp_e || out_valid !== 1'b1 || is_negative !== (m == 0 && i >= 4)) begin
                    errors++;
                    $display("FAIL sweep mode=%0d in=%0d: ext=%h valid=%b neg=%b, want %h/1",
                             m, i, extended_bits, out_valid, is_negative, exp_e);
                end
            end
        end
    endtask

    task automatic test_hold();
        step(1'b1, 3'b110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'($urandom), 1'($urandom));
            checks++;
            if (extended_bits !== 8'hFE || out_valid !== 1'b0 || is_negative !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: ext=%h valid=%b neg=%b, want FE/0/1", i, extended_bits, out_valid, is_negative);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 3'b101, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (extended_bits !== 8'h00 || out_valid !== 1'b0 || is_negative !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ext=%h valid=%b neg=%b, want 00/0/0", extended_bits, out_valid, is_negative);
        end
        @(posedge clk);
        #1;
        checks++;
        if (extended_bits !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: ext=%h valid=%b, want 00/0", extended_bits, out_valid);
        end
        rst_n = 1'b1;
        step(1'b1, 3'b011, 1'b1);
        checks++;
        if (extended_bits !== 8'h03 || out_valid !== 1'b1 || is_negative !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: ext=%h valid=%b neg=%b, want 03/1/0", extended_bits, out_valid, is_negative);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_e;
        logic       v, z;
        logic [2:0] b;
        step(1'b1, 3'b000, 1'b1);
        exp_e = 8'h00;
        for (int i = 0; i < 60; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            b = 3'($urandom);
            z = 1'($urandom);
            step(v, b, z);
            if (v) exp_e = ref_ext(b, z);
            checks++;
            if (extended_bits !== exp_e || out_valid !== v || is_negative !== exp_e[7]) begin
                errors++;
                $display("FAIL random[%0d] v=%b in=%b z=%b: ext=%h valid=%b neg=%b, want %h/%b/%b",
                         i, v, b, z, extended_bits, out_valid, is_negative, exp_e, v, exp_e[7]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
